// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : 4-digit display scan scheduler with blanking between digits
//               and a tear-free frame register loaded at frame boundaries.
//               Optional macro LEADING_ZERO_BLANK_EN darkens leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int TICKS_PER_DIGIT = 27000,
    parameter int BLANK_TICKS     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] frame_data,
    output logic [1:0]  sel,
    output logic [3:0]  an_n,
    output logic        frame_start
);

    localparam int c_MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int c_CNT_W     = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;

    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(TICKS_PER_DIGIT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BLANK = 2'd1;
    localparam logic [1:0] c_ST_SHOW  = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_sel;
    logic [3:0]         r_an_n;
    logic [15:0]        r_frame_data;
    logic [15:0]        r_pend;
    logic               r_pend_full;
    logic               r_frame_start;

    logic               w_digit_lit;
    logic [3:0]         w_show_an;

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k stays dark when it and every more-significant nibble are zero.
    assign w_digit_lit = (r_sel == 2'd0) || ((r_frame_data >> {r_sel, 2'b00}) != 16'd0);
`else
    assign w_digit_lit = 1'b1;
`endif

    assign w_show_an = w_digit_lit ? ~(4'b0001 << r_sel) : 4'b1111;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_sel         <= 2'd0;
            r_an_n        <= 4'b1111;
            r_frame_data  <= 16'd0;
            r_pend        <= 16'd0;
            r_pend_full   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;

            // Accept and transfer are exclusive: one needs pend empty, the other full.
            if (data_valid && !r_pend_full) begin
                r_pend      <= data_in;
                r_pend_full <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_an_n <= 4'b1111;
                    r_sel  <= 2'd0;
                    r_cnt  <= '0;
                    if (r_pend_full) begin
                        r_frame_data <= r_pend;
                        r_pend_full  <= 1'b0;
                    end
                    if (en) begin
                        r_state       <= c_ST_BLANK;
                        r_frame_start <= 1'b1;
                    end
                end

                c_ST_BLANK: begin
                    if (!en) begin
                        r_state <= c_ST_IDLE;
                        r_an_n  <= 4'b1111;
                        r_sel   <= 2'd0;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_BLANK_LAST) begin
                        r_state <= c_ST_SHOW;
                        r_cnt   <= '0;
                        r_an_n  <= w_show_an;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_SHOW: begin
                    if (!en) begin
                        r_state <= c_ST_IDLE;
                        r_an_n  <= 4'b1111;
                        r_sel   <= 2'd0;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_SHOW_LAST) begin
                        r_state <= c_ST_BLANK;
                        r_cnt   <= '0;
                        r_an_n  <= 4'b1111;
                        r_sel   <= r_sel + 2'd1;
                        // Wrapping back to digit 0 is the only point the frame may change.
                        if (r_sel == 2'd3) begin
                            r_frame_start <= 1'b1;
                            if (r_pend_full) begin
                                r_frame_data <= r_pend;
                                r_pend_full  <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_an_n  <= 4'b1111;
                    r_sel   <= 2'd0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data_ready  = ~r_pend_full;
    assign frame_data  = r_frame_data;
    assign sel         = r_sel;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench for display_scan_ctrl against a slot/frame
//               arithmetic reference model (honours LEADING_ZERO_BLANK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int c_TPD   = 4;
    localparam int c_BLANK = 2;
    localparam int c_SLOT  = c_TPD + c_BLANK;
    localparam int c_FRAME = 4 * c_SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [15:0] frame_data;
    logic [1:0]  sel;
    logic [3:0]  an_n;
    logic        frame_start;

    display_scan_ctrl #(
        .TICKS_PER_DIGIT(c_TPD),
        .BLANK_TICKS    (c_BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_data (frame_data),
        .sel        (sel),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  an;
        logic [1:0]  sl;
        logic [15:0] fd;
        logic        rdy;
        logic        fs;
        logic [3:0]  nib;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: position in frame counted in cycles since frame start
    bit          m_run = 0;
    int          m_t = 0;
    bit          m_pf = 0;
    logic [15:0] m_pend = 16'd0;
    logic [15:0] m_frame = 16'd0;
    bit          m_accepted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            bit   acc;
            bit   xfer;
            bit   lit;
            int   slot;
            exp_t e;
            @(posedge clk);
            m_accepted = 0;
            if (!rst_n) begin
                m_run = 0; m_t = 0; m_pf = 0; m_pend = 16'd0; m_frame = 16'd0;
            end else begin
                acc  = data_valid && !m_pf;
                xfer = 0;
                if (!en) begin
                    xfer  = !m_run && m_pf;
                    m_run = 0;
                end else if (!m_run) begin
                    m_run = 1;
                    m_t   = 0;
                    xfer  = m_pf;
                end else begin
                    m_t  = m_t + 1;
                    xfer = ((m_t % c_FRAME) == 0) && m_pf;
                end
                if (xfer) begin
                    m_frame = m_pend;
                    m_pf    = 0;
                end
                if (acc) begin
                    m_pend     = data_in;
                    m_pf       = 1;
                    m_accepted = 1;
                end
            end
            if (m_run) begin
                slot = (m_t / c_SLOT) % 4;
                lit  = (m_t % c_SLOT) >= c_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
                if (slot != 0 && (m_frame >> (4 * slot)) == 16'd0) lit = 0;
`endif
                e.an = lit ? ~(4'(1) << slot) : 4'hF;
                e.sl = 2'(slot);
                e.fs = (m_t % c_FRAME) == 0;
            end else begin
                e.an = 4'hF;
                e.sl = 2'd0;
                e.fs = 1'b0;
            end
            e.fd  = m_frame;
            e.rdy = !m_pf;
            e.nib = 4'(m_frame >> (4 * e.sl));
            exp_q.push_back(e);
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [3:0] nib_act;
                e = exp_q.pop_front();
                nib_act = 4'(frame_data >> {sel, 2'b00});
                check("an_n",        {28'd0, an_n},        {28'd0, e.an});
                check("sel",         {30'd0, sel},         {30'd0, e.sl});
                check("frame_data",  {16'd0, frame_data},  {16'd0, e.fd});
                check("data_ready",  {31'd0, data_ready},  {31'd0, e.rdy});
                check("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
                check("mux_nibble",  {28'd0, nib_act},     {28'd0, e.nib});
            end
        end
    end

    task automatic offer(input logic [15:0] value);
        int n = 0;
        @(negedge clk);
        while (m_pf && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (m_pf) check("offer_timeout", 32'd1, 32'd0);
        data_in    = value;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_slot(input int k, input bit in_show);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = m_run && ((m_t / c_SLOT) % 4 == k) &&
                  (!in_show || ((m_t % c_SLOT) >= c_BLANK && (m_t % c_SLOT) < c_SLOT - 1));
        end
        if (!hit) check("wait_slot_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        // Reset, then idle with scan disabled
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Preload in IDLE, then start scanning
        offer(16'hF531);
        @(negedge clk);
        en = 1'b1;
        repeat (2 * c_FRAME) @(negedge clk);

        // Tear-free update offered mid-frame
        wait_slot(2, 0);
        data_in = 16'h1234; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (c_FRAME + 6) @(negedge clk);

        // Back-to-back offers under backpressure
        wait_slot(1, 0);
        data_in = 16'hAAAA; data_valid = 1'b1;
        @(negedge clk);
        data_in = 16'hBBBB;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (m_accepted) break;
        end
        if (!m_accepted) check("bbbb_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (2 * c_FRAME) @(negedge clk);

        // Enable drop during SHOW of digit 2, then resume
        wait_slot(2, 1);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (c_FRAME + 4) @(negedge clk);

        // Leading-zero patterns
        offer(16'h0050);
        repeat (2 * c_FRAME) @(negedge clk);
        offer(16'h0000);
        repeat (2 * c_FRAME) @(negedge clk);

        // Randomized enable/offers with data biased toward leading zeros
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en         = ($urandom_range(0, 39) != 0);
            data_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       data_in = 16'($urandom_range(0, 15));
                1:       data_in = 16'($urandom_range(0, 255));
                2:       data_in = 16'($urandom_range(0, 4095));
                default: data_in = 16'($urandom);
            endcase
        end
        data_valid = 1'b0;
        en = 1'b1;
        repeat (c_FRAME + 3) @(negedge clk);

        // Asynchronous reset mid-frame
        rst_n = 1'b0;
        #1;
        check("async_an_n",        {28'd0, an_n},        32'hF);
        check("async_sel",         {30'd0, sel},         32'd0);
        check("async_frame_data",  {16'd0, frame_data},  32'd0);
        check("async_data_ready",  {31'd0, data_ready},  32'd1);
        check("async_frame_start", {31'd0, frame_start}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        offer(16'h9876);
        repeat (c_FRAME + 6) @(negedge clk);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexing scheduler for the 4-digit, 16-bit display path.
- Drives the select of the 4:1 nibble mux (module_mux_41) and holds the tear-free 16-bit frame register that feeds the mux in_data.
- Generates the active-low digit anodes and inserts a blanking interval between digits to suppress ghosting.
- New display values enter through a valid/ready handshake and take effect only at frame boundaries.

Parameters:
- TICKS_PER_DIGIT, 27000, clk cycles a digit is lit per slot (>=1).
- BLANK_TICKS, 16, clk cycles all anodes are off before each digit (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable; low = display dark
- data_in  input  16  new display value, nibble k = digit k
- data_valid  input  1  data_in offered
- data_ready  output  1  pending slot free; transfer when valid && ready
- frame_data  output  16  stable frame register, wired to mux in_data
- sel  output  2  mux select / current digit index
- an_n  output  4  anode enables, active-low, at most one low
- frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - state=IDLE, sel=0, an_n=4'b1111, frame_data=0, pending empty, data_ready=1, frame_start=0, tick counter=0.
- Handshake:
  - valid&&ready at a clock edge captures data_in into the pending register.
  - On the same edge, pend_full=1 and data_ready=0.
  - data_ready=!pend_full. data_valid is ignored while data_ready=0.
- Frame transfer (pending to frame_data):
  - Occurs on the edge that enters BLANK for digit 0, if pend_full.
  - The same edge clears pend_full, so data_ready=1 the next cycle.
  - A new accept cannot coincide with a transfer, because ready was 0.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - an_n=1111, sel=0, counter=0.
  - If pend_full, transfer to frame_data immediately (next edge).
  - If en=1, go to BLANK for digit 0, apply the frame transfer rule, and assert frame_start in the first BLANK cycle.
- BLANK:
  - an_n=1111; sel already holds the new digit.
  - Lasts BLANK_TICKS cycles (counter 0..BLANK_TICKS-1), then enters SHOW with counter=0.
- SHOW:
  - an_n[sel]=0, all other bits 1.
  - Lasts TICKS_PER_DIGIT cycles, then enters BLANK with sel=sel+1 (mod 4, so 3 wraps to 0).
  - The wrap to 0 is a frame boundary: frame_start pulses in the first BLANK cycle of digit 0.
- Timing:
  - Slot = BLANK_TICKS+TICKS_PER_DIGIT cycles; frame = 4 slots.
  - Every state is held for exactly its tick count.
- en=0 in any state: next edge goes to IDLE with an_n=1111, sel=0, counter=0. The frame in progress is abandoned and the handshake remains operational.
- Counter width is $clog2(max(TICKS_PER_DIGIT,BLANK_TICKS)); there is no overflow beyond terminal count.
- All outputs are registered: no combinational path from inputs to outputs, and an_n is glitch-free.
- Reset mid-frame returns everything to reset values asynchronously. After reset release, the first frame begins per IDLE rules.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During SHOW for digit k in 1..3, an_n stays 1111 if frame_data nibbles k..3 are all zero.
  - Digit 0 is always lit; timing is unchanged.
- Undefined: all four digits are lit in their slots regardless of value.

Test Plan:
Bench uses TICKS_PER_DIGIT=4, BLANK_TICKS=2 (slot 6, frame 24 cycles).
- Reset/idle:
  - Stimulus: rst_n=0, then release with en=0 for 10 cycles.
  - Required: an_n=1111, sel=0, frame_data=0, data_ready=1, frame_start never high.
- Scan order:
  - Stimulus: preload 16'hF531 in IDLE, then en=1.
  - Required: frame_start pulses once; an_n sequence per slot is 2 cycles 1111 then 4 cycles 1110/1101/1011/0111 with sel 0/1/2/3; mux out 1,3,5,F; frame_start repeats every 24 cycles.
- Tear-free update:
  - Stimulus: mid-frame (sel=2), offer 16'h1234.
  - Required: accepted with data_ready dropping next cycle; frame_data stays F531 until the digit-0 BLANK entry; ready=1 the cycle after the transfer.
- Backpressure:
  - Stimulus: offer 16'hAAAA then 16'hBBBB back-to-back mid-frame.
  - Required: BBBB is not accepted until ready returns; the next frame shows AAAA and the following frame shows BBBB.
- Enable drop:
  - Stimulus: en=0 during SHOW of digit 2.
  - Required: next cycle an_n=1111, sel=0, IDLE. After re-enable, frame_start fires and the scan restarts at digit 0.
- LEADING_ZERO_BLANK_EN:
  - Stimulus: frame 16'h0050.
  - Required: digits 3 and 2 stay dark; digits 1 and 0 are lit. With 16'h0000 only digit 0 is lit.
